// File: rtl/multdiv_seq_unit.sv
// Sequential signed multiply (radix-2 shift-add) / divide (non-restoring) unit.
// Takes a one-cycle start pulse and produces a registered result with a one-cycle ready pulse WIDTH+1 edges later.
module multdiv_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH-1);
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ((~v) + ONE_W) : v;
    endfunction

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic               last_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH+1:0]   rem_r;
    logic [WIDTH-1:0]   b_mag_r;
    logic               neg_r;
    logic               div_zero_r;
    logic               div_ovf_r;

    logic               start_s;
    logic [WIDTH:0]     mul_add_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH+1:0]   rem_shift_s;
    logic [WIDTH+1:0]   rem_next_s;
    logic [WIDTH-1:0]   quo_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               mul_exc_s;
    logic [WIDTH-1:0]   quo_s;

    // One shift-add / shift-subtract step and the sign-corrected final values.
    always_comb begin
        start_s     = ctrl_MULT | ctrl_DIV;
        mul_add_s   = acc_r[0] ? {1'b0, b_mag_r} : {(WIDTH+1){1'b0}};
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + mul_add_s;
        mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
        rem_shift_s = {rem_r[WIDTH:0], acc_r[WIDTH-1]};
        if (rem_r[WIDTH+1]) begin
            rem_next_s = rem_shift_s + {2'b00, b_mag_r};
        end else begin
            rem_next_s = rem_shift_s - {2'b00, b_mag_r};
        end
        quo_next_s  = {acc_r[WIDTH-2:0], ~rem_next_s[WIDTH+1]};
        prod_s      = neg_r ? ((~acc_r) + ONE_2W) : acc_r;
        mul_exc_s   = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
        quo_s       = neg_r ? ((~acc_r[WIDTH-1:0]) + ONE_W) : acc_r[WIDTH-1:0];
    end

    // Control FSM, iteration datapath and registered outputs; a start pulse always wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            cnt_r          <= {CW{1'b0}};
            last_r         <= 1'b0;
            acc_r          <= {(2*WIDTH){1'b0}};
            rem_r          <= {(WIDTH+2){1'b0}};
            b_mag_r        <= {WIDTH{1'b0}};
            neg_r          <= 1'b0;
            div_zero_r     <= 1'b0;
            div_ovf_r      <= 1'b0;
            data_result    <= {WIDTH{1'b0}};
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (start_s) begin
            state_r        <= ctrl_MULT ? MUL : DIV;
            cnt_r          <= {CW{1'b0}};
            last_r         <= 1'b0;
            acc_r          <= {{WIDTH{1'b0}}, mag(data_operandA)};
            rem_r          <= {(WIDTH+2){1'b0}};
            b_mag_r        <= mag(data_operandB);
            neg_r          <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero_r     <= (data_operandB == {WIDTH{1'b0}});
            div_ovf_r      <= (data_operandA == MIN_W) && (data_operandB == {WIDTH{1'b1}});
            data_resultRDY <= 1'b0;
        end else begin
            case (state_r)
                MUL, DIV: begin
                    if (last_r) begin
                        state_r        <= DONE;
                        data_resultRDY <= 1'b1;
                        if (state_r == MUL) begin
                            data_result    <= prod_s[WIDTH-1:0];
                            data_exception <= mul_exc_s;
                        end else if (div_zero_r) begin
                            data_result    <= {WIDTH{1'b0}};
                            data_exception <= 1'b1;
                        end else begin
                            data_result    <= quo_s;
                            data_exception <= div_ovf_r;
                        end
                    end else begin
                        if (state_r == MUL) begin
                            acc_r <= mul_next_s;
                        end else begin
                            rem_r <= rem_next_s;
                            acc_r <= {acc_r[2*WIDTH-1:WIDTH], quo_next_s};
                        end
                        if (cnt_r == CNT_LAST) begin
                            last_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                DONE: begin
                    state_r        <= IDLE;
                    data_resultRDY <= 1'b0;
                end
                IDLE: begin
                    data_resultRDY <= 1'b0;
                end
                default: begin
                    state_r        <= IDLE;
                    data_resultRDY <= 1'b0;
                end
            endcase
        end
    end

endmodule
